gemm_result_writer: RTL and testbench

- Downstream neighbour of the GeMM controller and accumulator array.
- On each result-valid pulse, captures the finished C tile together with its M/N block indices into a small FIFO.
- Serialises each tile word-by-word onto the output (C) SRAM write port using a req/gnt handshake.
- Decouples accumulator completion from SRAM write bandwidth, and signals when all results of a GeMM run have been written.

---
 rtl/gemm_writer_pkg.sv | 13 +
 rtl/gemm_tile_fifo.sv | 62 ++++++
 rtl/gemm_result_writer.sv | 179 +++++++++++++++++
 tb/tb_gemm_result_writer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_writer_pkg.sv
// Shared types and default widths for the GeMM result writer.
package gemm_writer_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefTileWords = 4;

    typedef enum logic [1:0] {
        WrIdle,
        WrDrain,
        WrFlush
    } writer_state_t;

endpackage

// File: rtl/gemm_tile_fifo.sv
// Synchronous FIFO of tile entries; accepts a push while full when a pop
// happens in the same cycle.
module gemm_tile_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the occupancy counter gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/gemm_result_writer.sv
// Buffers finished C tiles and serialises them onto the C SRAM write port.
// Optional stall counter port is enabled by defining GEMM_WRITER_PERF_EN.
module gemm_result_writer
    import gemm_writer_pkg::*;
#(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned TileWords = DefTileWords,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           result_valid_i,
    input  logic [TileWords*DataWidth-1:0] tile_data_i,
    input  logic [AddrWidth-1:0]           M_idx_i,
    input  logic [AddrWidth-1:0]           N_idx_i,
    input  logic [AddrWidth-1:0]           N_size_i,
    input  logic                           gemm_done_i,
    output logic                           sram_req_o,
    input  logic                           sram_gnt_i,
    output logic [AddrWidth-1:0]           sram_addr_o,
    output logic [DataWidth-1:0]           sram_wdata_o,
    output logic                           busy_o,
    output logic                           flush_done_o,
    output logic                           overflow_o
`ifdef GEMM_WRITER_PERF_EN
    ,
    output logic [31:0]                    stall_cycles_o
`endif
);

    localparam int unsigned WordW  = $clog2(TileWords);
    localparam int unsigned TileW  = TileWords * DataWidth;
    localparam int unsigned EntryW = TileW + AddrWidth;
    localparam int unsigned CntW   = $clog2(FifoDepth) + 1;

    writer_state_t         state_q, state_d;
    logic [WordW-1:0]      word_q, word_d;
    logic                  done_q;
    logic                  overflow_q;

    logic [AddrWidth-1:0]  lin_idx;
    logic [AddrWidth-1:0]  cap_base;
    logic [EntryW-1:0]     head_entry;
    logic [TileW-1:0]      head_tile;
    logic [AddrWidth-1:0]  head_base;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntW-1:0]       fifo_count;

    logic                  last_word;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic                  more_left;

    // Only the low AddrWidth bits of the product survive, so wrapping
    // arithmetic at AddrWidth yields the same base address.
    assign lin_idx  = M_idx_i * N_size_i + N_idx_i;
    assign cap_base = lin_idx << WordW;

    gemm_tile_fifo #(
        .Width (EntryW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (result_valid_i),
        .data_i  ({tile_data_i, cap_base}),
        .pop_i   (pop),
        .head_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_tile = head_entry[EntryW-1 -: TileW];
    assign head_base = head_entry[AddrWidth-1:0];

    assign last_word = (word_q == WordW'(TileWords - 1));
    assign pop       = (state_q == WrDrain) && sram_gnt_i && last_word;
    assign push_ok   = result_valid_i && (!fifo_full || pop);
    assign drop      = result_valid_i && fifo_full && !pop;
    assign more_left = (fifo_count > CntW'(1)) || push_ok;

    // Idle also wakes on the capturing push itself so the first request
    // follows result_valid_i by one cycle; a drain that empties the FIFO
    // with the done latch set goes straight to the flush pulse.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        sram_req_o   = 1'b0;
        flush_done_o = 1'b0;
        unique case (state_q)
            WrIdle: begin
                if (!fifo_empty || push_ok) begin
                    state_d = WrDrain;
                end else if (done_q) begin
                    state_d = WrFlush;
                end
            end
            WrDrain: begin
                sram_req_o = 1'b1;
                if (sram_gnt_i) begin
                    if (last_word) begin
                        word_d = '0;
                        if (more_left) begin
                            state_d = WrDrain;
                        end else if (done_q) begin
                            state_d = WrFlush;
                        end else begin
                            state_d = WrIdle;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            WrFlush: begin
                flush_done_o = 1'b1;
                state_d      = WrIdle;
            end
            default: state_d = WrIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WrIdle;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
        end else if (gemm_done_i) begin
            done_q <= 1'b1;
        end else if (start_i || (state_q == WrFlush)) begin
            done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (start_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow_o   = overflow_q;
    assign busy_o       = !fifo_empty || (state_q != WrIdle);
    assign sram_addr_o  = sram_req_o ? (head_base + AddrWidth'(word_q)) : '0;
    assign sram_wdata_o = sram_req_o ? head_tile[word_q*DataWidth +: DataWidth] : '0;

`ifdef GEMM_WRITER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (start_i) begin
            stall_q <= '0;
        end else if (sram_req_o && !sram_gnt_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_gemm_result_writer.sv
// Scoreboard bench for gemm_result_writer: expected SRAM writes are queued
// when tiles are driven and checked as grants occur.
module tb_gemm_result_writer;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;
    localparam int unsigned FD = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            rvalid;
    logic [TW*DW-1:0] tile;
    logic [AW-1:0]   m_idx;
    logic [AW-1:0]   n_idx;
    logic [AW-1:0]   n_size;
    logic            gdone;
    logic            req;
    logic            gnt;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            busy;
    logic            flush;
    logic            ovf;
`ifdef GEMM_WRITER_PERF_EN
    logic [31:0]     stall;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned gcount = 0;
    int unsigned last_grant_cyc = 0;
    wr_t         sb[$];
    wr_t         mon_e;

    gemm_result_writer #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .TileWords (TW),
        .FifoDepth (FD)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .result_valid_i (rvalid),
        .tile_data_i    (tile),
        .M_idx_i        (m_idx),
        .N_idx_i        (n_idx),
        .N_size_i       (n_size),
        .gemm_done_i    (gdone),
        .sram_req_o     (req),
        .sram_gnt_i     (gnt),
        .sram_addr_o    (addr),
        .sram_wdata_o   (wdata),
        .busy_o         (busy),
        .flush_done_o   (flush),
        .overflow_o     (ovf)
`ifdef GEMM_WRITER_PERF_EN
        ,
        .stall_cycles_o (stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && req && gnt) begin
            gcount++;
            last_grant_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", addr, wdata);
            end else begin
                mon_e = sb.pop_front();
                if ({addr, wdata} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sram_write: got addr=%h data=%h, expected addr=%h data=%h",
                             addr, wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] exp_base(input int unsigned m, input int unsigned n,
                                               input int unsigned ns);
        longint unsigned v;
        v = (longint'(m) * longint'(ns) + longint'(n)) * longint'(TW);
        return AW'(v);
    endfunction

    task automatic drive_tile(input int unsigned m, input int unsigned n, input logic done,
                              input bit keep);
        logic [AW-1:0] base;
        logic [DW-1:0] word;
        base = exp_base(m, n, n_size);
        for (int w = 0; w < int'(TW); w++) begin
            word = $urandom;
            tile[w*DW +: DW] = word;
            if (keep) sb.push_back('{addr: base + AW'(w), data: word});
        end
        m_idx  = AW'(m);
        n_idx  = AW'(n);
        rvalid = 1'b1;
        gdone  = done;
        @(posedge clk); #1;
        rvalid = 1'b0;
        gdone  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((busy || sb.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (busy || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%0b pending=%0d, expected busy=0 pending=0",
                     busy, sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({req, busy, flush, ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got req/busy/flush/ovf=%b, expected 0000",
                     {req, busy, flush, ovf});
        end
        n_cmp++;
        if ({addr, wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h data=%h, expected 0", addr, wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got req/busy=%b, expected 00", {req, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        drive_tile(1, 2, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                n_cmp++;
                if (req !== 1'b1 || addr !== AW'(20 + k - 1)) begin
                    n_fail++;
                    $display("FAIL single_word%0d: got req=%b addr=%0d, expected req=1 addr=%0d",
                             k - 1, req, addr, 20 + k - 1);
                end
            end else begin
                n_cmp++;
                if (busy !== 1'b0 || req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_busy_fall: got busy=%b req=%b, expected 0 0", busy, req);
                end
            end
        end
        wait_idle(20);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int unsigned g0;
        int unsigned bubbles;
        g0 = gcount;
        bubbles = 0;
        drive_tile(0, 0, 1'b0, 1'b1);
        drive_tile(0, 1, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (req !== 1'b1) bubbles++;
        end
        n_cmp++;
        if (bubbles != 0) begin
            n_fail++;
            $display("FAIL b2b_bubbles: got %0d idle cycles, expected 0", bubbles);
        end
        @(negedge clk);
        n_cmp++;
        if (gcount - g0 != 8 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_grants: got %0d grants req=%b, expected 8 grants req=0",
                     gcount - g0, req);
        end
        wait_idle(20);
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int unsigned g0;
        logic [DW-1:0] d2;
        pulse_start();
        drive_tile(2, 0, 1'b0, 1'b1);
        d2 = tile[2*DW +: DW];
        @(posedge clk); #1;
        @(posedge clk); #1;
        gnt = 1'b0;
        g0 = gcount;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req !== 1'b1 || addr !== AW'(26) || wdata !== d2) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got req=%b addr=%0d data=%h, expected req=1 addr=26 data=%h",
                         i, req, addr, wdata, d2);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (gcount != g0) begin
            n_fail++;
            $display("FAIL stall_no_grant: got %0d grants, expected 0", gcount - g0);
        end
        gnt = 1'b1;
        wait_idle(20);
`ifdef GEMM_WRITER_PERF_EN
        n_cmp++;
        if (stall !== 32'd5) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, expected 5", stall);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        pulse_start();
        gnt = 1'b0;
        drive_tile(3, 0, 1'b0, 1'b1);
        drive_tile(3, 1, 1'b0, 1'b1);
        drive_tile(3, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ovf !== 1'b1 || req !== 1'b1 || addr !== AW'(36)) begin
                n_fail++;
                $display("FAIL ovf_hold%0d: got ovf=%b req=%b addr=%0d, expected ovf=1 req=1 addr=36",
                         i, ovf, req, addr);
            end
        end
        @(posedge clk); #1;
        gnt = 1'b1;
        wait_idle(40);
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b, expected 1", ovf);
        end
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, expected 0", ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int unsigned t;
        int unsigned fcount;
        int unsigned fcyc;
        gnt = 1'b1;
        pulse_start();
        t = cyc;
        fcount = 0;
        fcyc = 0;
        drive_tile(1, 1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (flush === 1'b1) begin
                fcount++;
                fcyc = cyc;
            end
        end
        n_cmp++;
        if (fcount != 1 || fcyc != t + 5) begin
            n_fail++;
            $display("FAIL flush_pulse: got %0d pulses at cycle %0d, expected 1 pulse at cycle %0d",
                     fcount, fcyc, t + 5);
        end
        n_cmp++;
        if (last_grant_cyc != t + 4) begin
            n_fail++;
            $display("FAIL flush_last_grant: got cycle %0d, expected %0d", last_grant_cyc, t + 4);
        end
        wait_idle(20);
        @(posedge clk); #1;
    endtask

    task automatic test_addr_wrap();
        drive_tile(32'h5555, 2, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (req !== 1'b1 || addr !== AW'(4)) begin
            n_fail++;
            $display("FAIL addr_wrap: got req=%b addr=%h, expected req=1 addr=0004", req, addr);
        end
        wait_idle(20);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int unsigned g0;
        int unsigned stray;
        gnt = 1'b1;
        g0 = gcount;
        drive_tile(0, 1, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        n_cmp++;
        if (req !== 1'b0 || busy !== 1'b0 || gcount - g0 != 2) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%b busy=%b grants=%0d, expected req=0 busy=0 grants=2",
                     req, busy, gcount - g0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        g0 = gcount;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0 || gcount != g0) begin
            n_fail++;
            $display("FAIL reset_no_writes: got %0d req cycles, expected 0", stray);
        end
        @(posedge clk); #1;
        drive_tile(2, 2, 1'b0, 1'b1);
        wait_idle(20);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        rvalid = 1'b0;
        gdone  = 1'b0;
        tile   = '0;
        m_idx  = '0;
        n_idx  = '0;
        n_size = AW'(3);
        gnt    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_flush();
        test_addr_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
